// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: EX-stage multiply/divide sequencer.
// Iterative shift-add multiplier (32 cycles) and restoring divider
// (32 cycles); result is {hi, lo} = product or {remainder, quotient}.
// Optional build macro: MULT_DIV_FAST_MULT_EN selects a single-cycle
// multiplier instead of the shift-add sequence (divide stays iterative).
module mult_div_ctrl #(
  parameter logic [5:0] FUNCT_MULT  = 6'h18,
  parameter logic [5:0] FUNCT_MULTU = 6'h19,
  parameter logic [5:0] FUNCT_DIV   = 6'h1A,
  parameter logic [5:0] FUNCT_DIVU  = 6'h1B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [5:0]  funct,
  input  logic [31:0] operand_1,
  input  logic [31:0] operand_2,
  output logic        busy,
  output logic        done,
  output logic [63:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic        neg_q;   // product / quotient gets negated
  logic        neg_r;   // remainder takes negative dividend sign
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] rem;
  logic [31:0] quo;

  // decode of the instruction sitting in EX
  logic        is_mul, is_div, is_sgn, start, div0;
  logic [31:0] in_a, in_b;
  logic        neg_q_in, neg_r_in;

  assign is_mul   = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
  assign is_div   = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  assign is_sgn   = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  assign start    = (state == S_IDLE) && (is_mul || is_div) && !flush;
  assign div0     = is_div && (operand_2 == 32'd0);
  // 0x8000_0000 maps onto itself, which is the correct unsigned magnitude
  assign in_a     = (is_sgn && operand_1[31]) ? (~operand_1 + 32'd1) : operand_1;
  assign in_b     = (is_sgn && operand_2[31]) ? (~operand_2 + 32'd1) : operand_2;
  assign neg_q_in = is_sgn && (operand_1[31] ^ operand_2[31]);
  assign neg_r_in = is_sgn && operand_1[31];

  // one restoring-division step: shift in the next dividend bit, trial subtract
  logic [33:0] div_shift, div_trial;
  logic        div_ok;
  logic [32:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [63:0] div_res;

  assign div_shift = {rem, quo[31]};
  assign div_trial = div_shift - {2'b00, abs_b};
  assign div_ok    = ~div_trial[33];
  assign rem_nxt   = div_ok ? div_trial[32:0] : div_shift[32:0];
  assign quo_nxt   = {quo[30:0], div_ok};
  assign div_res   = {(neg_r ? (~rem_nxt[31:0] + 32'd1) : rem_nxt[31:0]),
                      (neg_q ? (~quo_nxt + 32'd1) : quo_nxt)};

`ifdef MULT_DIV_FAST_MULT_EN
  // full product straight from the operand magnitudes
  logic [63:0] fast_prod, fast_res;
  assign fast_prod = {32'd0, in_a} * {32'd0, in_b};
  assign fast_res  = neg_q_in ? (~fast_prod + 64'd1) : fast_prod;
`else
  // shift-add step: hi half accumulates, multiplier drains out of lo half
  logic [63:0] prod;
  logic [32:0] mul_sum;
  logic [63:0] prod_nxt, mul_res;
  assign mul_sum  = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, abs_a} : 33'd0);
  assign prod_nxt = {mul_sum, prod[31:1]};
  assign mul_res  = neg_q ? (~prod_nxt + 64'd1) : prod_nxt;
`endif

  // sequencing FSM with registered busy/done/result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= 6'd0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      abs_a  <= 32'd0;
      abs_b  <= 32'd0;
      rem    <= 33'd0;
      quo    <= 32'd0;
`ifndef MULT_DIV_FAST_MULT_EN
      prod   <= 64'd0;
`endif
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 64'd0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: if (start) begin
            neg_q <= neg_q_in;
            neg_r <= neg_r_in;
            abs_a <= in_a;
            abs_b <= in_b;
            quo   <= in_a;
            rem   <= 33'd0;
`ifndef MULT_DIV_FAST_MULT_EN
            prod  <= {32'd0, in_b};
`endif
            cnt   <= 6'd0;
            if (div0) begin
              // divide by zero: dividend in hi, all-ones quotient, no iteration
              state  <= S_DONE;
              done   <= 1'b1;
              result <= {operand_1, 32'hFFFF_FFFF};
            end else if (is_mul) begin
`ifdef MULT_DIV_FAST_MULT_EN
              state  <= S_DONE;
              done   <= 1'b1;
              result <= fast_res;
`else
              state  <= S_MUL;
              busy   <= 1'b1;
`endif
            end else begin
              state <= S_DIV;
              busy  <= 1'b1;
            end
          end
`ifndef MULT_DIV_FAST_MULT_EN
          S_MUL: begin
            prod <= prod_nxt;
            cnt  <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              state  <= S_DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              result <= mul_res;
            end
          end
`endif
          S_DIV: begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              state  <= S_DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              result <= div_res;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
